// File: rtl/key_command_decoder_pkg.sv
// key_command_decoder_pkg: scan-code type, default key map and key slot indices.
package key_command_decoder_pkg;
  typedef logic [8:0] keycode_t;
  localparam keycode_t KEY_LEFT_DEF = 9'h06B;
  localparam keycode_t KEY_RIGHT_DEF = 9'h074;
  localparam keycode_t KEY_FIRE_DEF = 9'h029;
  localparam keycode_t KEY_START_DEF = 9'h05A;
  localparam keycode_t KEY_PAUSE_DEF = 9'h04D;
  localparam keycode_t KEY_SKIP_DEF = 9'h01B;
  localparam int FIRE_REPEAT_DEF = 8;
  localparam int NUM_KEYS = 6;
  typedef enum int {K_LEFT, K_RIGHT, K_FIRE, K_START, K_PAUSE, K_SKIP} key_idx_e;
endpackage

// File: rtl/key_command_decoder_if.sv
// key_command_decoder_if: keyboard events and frame/enable in, game commands out.
interface key_command_decoder_if;
  import key_command_decoder_pkg::*;
  keycode_t keyCode;
  logic make;
  logic brake;
  logic startOfFrame;
  logic enable;
  logic move_left;
  logic move_right;
  logic fire_pulse;
  logic start_pulse;
  logic skip_pulse;
  logic pause_level;
  modport master (output keyCode, make, brake, startOfFrame, enable,
                  input move_left, move_right, fire_pulse, start_pulse, skip_pulse, pause_level);
  modport slave (input keyCode, make, brake, startOfFrame, enable,
                 output move_left, move_right, fire_pulse, start_pulse, skip_pulse, pause_level);
endinterface

// File: rtl/key_command_decoder_key_edge_tracker.sv
// key_edge_tracker: one held bit per key; brake beats make, repeats of a held key give no rise.
module key_edge_tracker (
  input  logic clk,
  input  logic resetN,
  input  logic i_match,
  input  logic i_make,
  input  logic i_brake,
  input  logic i_clear,
  output logic o_held_nxt,
  output logic o_rise
);
  logic r_held;
  always_comb o_held_nxt = (i_clear | (i_match & i_brake)) ? 1'b0 : (i_match & i_make) ? 1'b1 : r_held;
  assign o_rise = o_held_nxt & ~r_held;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_held <= 1'b0;
    else r_held <= o_held_nxt;
endmodule

// File: rtl/key_command_decoder.sv
// key_command_decoder: maps keyboard make/brake events to registered game commands.
// Define KEY_AUTOFIRE_EN to add frame-based autofire while fire is held.
module key_command_decoder
  import key_command_decoder_pkg::*;
#(
  parameter keycode_t KEY_LEFT = KEY_LEFT_DEF,
  parameter keycode_t KEY_RIGHT = KEY_RIGHT_DEF,
  parameter keycode_t KEY_FIRE = KEY_FIRE_DEF,
  parameter keycode_t KEY_START = KEY_START_DEF,
  parameter keycode_t KEY_PAUSE = KEY_PAUSE_DEF,
  parameter keycode_t KEY_SKIP = KEY_SKIP_DEF,
  parameter int FIRE_REPEAT_FRAMES = FIRE_REPEAT_DEF
) (
  input logic clk,
  input logic resetN,
  key_command_decoder_if.slave bus
);
  localparam logic [9*NUM_KEYS-1:0] KEY_MAP = {KEY_SKIP, KEY_PAUSE, KEY_START, KEY_FIRE, KEY_RIGHT, KEY_LEFT};
  logic [NUM_KEYS-1:0] w_nxt, w_rise;
  logic w_af_tick;
  logic r_move_left, r_move_right, r_fire, r_start, r_skip, r_pause;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_edge_tracker u_trk (
      .clk(clk), .resetN(resetN),
      .i_match(bus.keyCode == KEY_MAP[9*k +: 9]),
      .i_make(bus.make), .i_brake(bus.brake),
      .i_clear((k == int'(K_FIRE)) ? ~bus.enable : 1'b0),
      .o_held_nxt(w_nxt[k]), .o_rise(w_rise[k])
    );
  end
`ifdef KEY_AUTOFIRE_EN
  localparam logic [5:0] AF_LAST = 6'(FIRE_REPEAT_FRAMES - 1);
  logic [5:0] r_af_cnt;
  logic w_af_count;
  // frames only count while fire stays held; a fresh press or a release restarts the period
  assign w_af_count = w_nxt[K_FIRE] & ~w_rise[K_FIRE] & bus.startOfFrame;
  assign w_af_tick = w_af_count & (r_af_cnt == AF_LAST);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_af_cnt <= '0;
    else if (!w_nxt[K_FIRE] || w_rise[K_FIRE]) r_af_cnt <= '0;
    else if (w_af_count) r_af_cnt <= w_af_tick ? 6'd0 : r_af_cnt + 6'd1;
`else
  assign w_af_tick = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_move_left <= 1'b0;
      r_move_right <= 1'b0;
      r_fire <= 1'b0;
      r_start <= 1'b0;
      r_skip <= 1'b0;
      r_pause <= 1'b0;
    end else begin
      r_move_left <= w_nxt[K_LEFT] & ~w_nxt[K_RIGHT] & bus.enable;
      r_move_right <= w_nxt[K_RIGHT] & ~w_nxt[K_LEFT] & bus.enable;
      r_fire <= ((w_rise[K_FIRE] & bus.enable) | w_af_tick) & ~r_fire;
      r_start <= w_rise[K_START] & ~r_start;
      r_skip <= w_rise[K_SKIP] & ~r_skip;
      r_pause <= r_pause ^ w_rise[K_PAUSE];
    end
  assign bus.move_left = r_move_left;
  assign bus.move_right = r_move_right;
  assign bus.fire_pulse = r_fire;
  assign bus.start_pulse = r_start;
  assign bus.skip_pulse = r_skip;
  assign bus.pause_level = r_pause;
endmodule

// File: tb/tb_key_command_decoder.sv
// tb_key_command_decoder: scenario tasks push expected output vectors and compare after each clock.
// Output vector order: {move_left, move_right, fire_pulse, start_pulse, skip_pulse, pause_level}.
module tb_key_command_decoder;
  import key_command_decoder_pkg::*;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  key_command_decoder_if bus ();
  key_command_decoder dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic [5:0] exp_q[$];
  logic [5:0] got, want;
  function automatic logic [5:0] outs();
    return {bus.move_left, bus.move_right, bus.fire_pulse, bus.start_pulse, bus.skip_pulse, bus.pause_level};
  endfunction
  task automatic drive(input keycode_t c, input logic mk, input logic br, input logic sof);
    bus.keyCode = c;
    bus.make = mk;
    bus.brake = br;
    bus.startOfFrame = sof;
    @(posedge clk);
    #1;
    bus.make = 1'b0;
    bus.brake = 1'b0;
    bus.startOfFrame = 1'b0;
  endtask
  task automatic test_reset();
    bus.keyCode = '0; bus.make = 1'b0; bus.brake = 1'b0; bus.startOfFrame = 1'b0; bus.enable = 1'b1;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(6'b000000);
    got = outs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset: got %b want %b", got, want); end
    resetN = 1'b1;
  endtask
  task automatic test_left();
    for (int i = 0; i < 25; i++) begin
      exp_q.push_back((i >= 10 && i < 20) ? 6'b100000 : 6'b000000);
      drive(9'h06B, i == 10, i == 20, 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL left cycle %0d: got %b want %b", i + 1, got, want); end
    end
  endtask
  task automatic test_both();
    keycode_t c[5] = '{9'h06B, 9'h074, 9'h000, 9'h06B, 9'h074};
    logic [1:0] mb[5] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    logic [5:0] e[5] = '{6'b100000, 6'b000000, 6'b000000, 6'b010000, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(e[i]);
      drive(c[i], mb[i][1], mb[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL both step %0d: got %b want %b", i, got, want); end
    end
  endtask
  task automatic test_fire_repeat();
    int pulses = 0;
    logic [1:0] mb[5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [5:0] e[5] = '{6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(e[i]);
      drive(9'h029, mb[i][1], mb[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      pulses += int'(got[3]);
      if (got !== want) begin n_fail++; $display("FAIL fire_repeat step %0d: got %b want %b", i, got, want); end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL fire_repeat count: got %0d want 1", pulses); end
  endtask
  task automatic test_pause_enable();
    keycode_t c[9] = '{9'h04D, 9'h04D, 9'h04D, 9'h04D, 9'h029, 9'h05A, 9'h05A, 9'h029, 9'h06B};
    logic [1:0] mb[9] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
    logic en[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] e[9] = '{6'b000001, 6'b000001, 6'b000000, 6'b000000, 6'b000000,
                         6'b000100, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 9; i++) begin
      bus.enable = en[i];
      exp_q.push_back(e[i]);
      drive(c[i], mb[i][1], mb[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL pause_enable step %0d: got %b want %b", i, got, want); end
    end
    bus.enable = 1'b1;
    exp_q.push_back(6'b100000);
    drive(9'h000, 1'b0, 1'b0, 1'b0);
    got = outs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL unmask_left: got %b want %b", got, want); end
    drive(9'h06B, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_back_to_back();
    keycode_t c[8] = '{9'h0AA, 9'h06B, 9'h05A, 9'h05A, 9'h05A, 9'h05A, 9'h01B, 9'h01B};
    logic [1:0] mb[8] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [5:0] e[8] = '{6'b000000, 6'b000000, 6'b000100, 6'b000000, 6'b000100,
                         6'b000000, 6'b000010, 6'b000000};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      drive(c[i], mb[i][1], mb[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL back_to_back step %0d: got %b want %b", i, got, want); end
    end
  endtask
  task automatic test_autofire();
    int pulses = 0;
    exp_q.push_back(6'b001000);
    drive(9'h029, 1'b1, 1'b0, 1'b0);
    got = outs(); want = exp_q.pop_front(); n_checks++;
    pulses += int'(got[3]);
    if (got !== want) begin n_fail++; $display("FAIL autofire press: got %b want %b", got, want); end
    for (int i = 0; i < 80; i++) begin
`ifdef KEY_AUTOFIRE_EN
      exp_q.push_back((i % 4 == 0 && ((i / 4 + 1) % 8) == 0) ? 6'b001000 : 6'b000000);
`else
      exp_q.push_back(6'b000000);
`endif
      drive(9'h000, 1'b0, 1'b0, i % 4 == 0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      pulses += int'(got[3]);
      if (got !== want) begin n_fail++; $display("FAIL autofire step %0d: got %b want %b", i, got, want); end
    end
    drive(9'h029, 1'b0, 1'b1, 1'b0);
    n_checks++;
`ifdef KEY_AUTOFIRE_EN
    if (pulses != 3) begin n_fail++; $display("FAIL autofire count: got %0d want 3", pulses); end
`else
    if (pulses != 1) begin n_fail++; $display("FAIL autofire count: got %0d want 1", pulses); end
`endif
  endtask
  task automatic test_reset_mid();
    keycode_t c[3] = '{9'h04D, 9'h04D, 9'h06B};
    logic [1:0] mb[3] = '{2'b10, 2'b01, 2'b10};
    logic [5:0] e[3] = '{6'b000001, 6'b000001, 6'b100001};
    keycode_t c2[4] = '{9'h06B, 9'h000, 9'h06B, 9'h06B};
    logic [1:0] mb2[4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    logic [5:0] e2[4] = '{6'b000000, 6'b000000, 6'b100000, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e[i]);
      drive(c[i], mb[i][1], mb[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid pre step %0d: got %b want %b", i, got, want); end
    end
    #2;
    resetN = 1'b0;
    #1;
    exp_q.push_back(6'b000000);
    got = outs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_mid async: got %b want %b", got, want); end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e2[i]);
      drive(c2[i], mb2[i][1], mb2[i][0], 1'b0);
      got = outs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid post step %0d: got %b want %b", i, got, want); end
    end
  endtask
  initial begin
    test_reset();
    test_left();
    test_both();
    test_fire_repeat();
    test_pause_enable();
    test_back_to_back();
    test_autofire();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 SHALL have parameter KEY_LEFT, default 9'h06B, meaning the left-arrow scan code.
REQ-002 SHALL have parameter KEY_RIGHT, default 9'h074, meaning the right-arrow scan code.
REQ-003 SHALL have parameter KEY_FIRE, default 9'h029, meaning the space scan code.
REQ-004 SHALL have parameters KEY_START (9'h05A, Enter), KEY_PAUSE (9'h04D, P) and KEY_SKIP (9'h01B, S).
REQ-005 SHALL have parameter FIRE_REPEAT_FRAMES, default 8, meaning the autofire period in frames (1..63).
REQ-006 SHALL have ports: clk  in  1  system clock; resetN  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: keyCode  in  keycode (9)  scan code; make  in  1  press strobe; brake  in  1  release strobe.
REQ-008 SHALL have ports: startOfFrame  in  1  frame strobe; enable  in  1  gameplay enable.
REQ-009 SHALL have ports: move_left  out  1  level; move_right  out  1  level; fire_pulse  out  1  one-cycle pulse.
REQ-010 SHALL have ports: start_pulse  out  1; skip_pulse  out  1 (one-cycle pulses); pause_level  out  1  toggled pause state.

Function
REQ-011 SHALL keep one held bit per mapped key: set on a make with a matching keyCode, cleared on a brake with a matching keyCode.
REQ-012 SHALL ignore unmapped keyCodes and cycles where make and brake are both low.
REQ-013 SHALL give brake precedence when make and brake are asserted in the same cycle.
REQ-014 SHALL treat a make for an already-held key (typematic repeat) as no event: no pulse and no toggle.
REQ-015 SHALL register all outputs, with a latency of exactly 1 clk from the make/brake cycle.
REQ-016 SHALL drive move_left = held_left & ~held_right & enable, and move_right symmetrically; both keys held SHALL give 0/0.
REQ-017 SHALL issue fire_pulse on the held_fire 0->1 transition, but only while enable=1.
REQ-018 SHALL issue start_pulse and skip_pulse on their key's 0->1 held transition, independent of enable.
REQ-019 SHALL toggle pause_level on the KEY_PAUSE 0->1 held transition, independent of enable.
REQ-020 SHALL, when enable falls, clear held_fire and the autofire counter; move held bits keep tracking but outputs are masked.
REQ-021 SHALL never assert any two pulses on the same output in consecutive cycles.

Reset
REQ-022 SHALL, while resetN=0, drive all held bits, all outputs, pause_level and the autofire counter to 0 asynchronously.
REQ-023 SHALL start with all keys released after a reset mid-press; a later brake for that key is ignored and the next make counts as a fresh press.

Configuration
REQ-024 SHALL, with KEY_AUTOFIRE_EN defined, run a 6-bit frame counter while held_fire & enable.
REQ-025 SHALL, under KEY_AUTOFIRE_EN, emit fire_pulse in the cycle after every FIRE_REPEAT_FRAMES-th startOfFrame, then wrap the counter to 0.
REQ-026 SHALL zero the autofire counter on fire release or a new press.
REQ-027 SHALL, without KEY_AUTOFIRE_EN, contain no counter, with fire_pulse issued on the press edge only.

Structure
REQ-028 SHALL place the keycode typedef (9 bits) and the default scan-code constants in the shared parameters package.
REQ-029 SHALL use one natural sub-module, key_edge_tracker, which holds one held bit and produces a rise pulse, instantiated per key.

Verification
REQ-030 Bench SHALL cover: make 06B at cycle 10 -> move_left=1 at 11; brake 06B at 20 -> 0 at 21.
REQ-031 Bench SHALL cover: hold left, then make 074 -> both move outputs 0; brake 06B -> move_right=1 the next cycle.
REQ-032 Bench SHALL cover: make 029 three times without a brake, enable=1 -> exactly one fire_pulse (autofire off).
REQ-033 Bench SHALL cover, with KEY_AUTOFIRE_EN and FIRE_REPEAT_FRAMES=8: hold 029 for 20 frames -> 3 fire_pulses (press, frame 8, frame 16).
REQ-034 Bench SHALL cover: make/brake 04D twice -> pause_level 0->1->0; enable=0 during make 029 -> no fire_pulse, while start_pulse on 05A still fires.
REQ-035 Bench SHALL cover: hold 06B, assert resetN=0 mid-press -> all outputs 0 immediately; after release of reset, brake 06B -> no change.
